fft_stage_controller: RTL and testbench
=======================================

# fft_stage_controller

Sequencer for the in-place radix-2 decimation-in-time FFT built around the butterfly unit. On a start pulse it walks all log2(N) stages. For every butterfly it issues a read-address pair to the dual-port sample RAM and a twiddle-ROM address. It then delays those addresses to match the RAM read and butterfly pipeline latency and issues the matching write-back pair. Between stages it drains the pipeline so the next stage never reads stale data. It sits between the top-level control and the sample RAM / twiddle ROM / butterfly datapath.

## Interface
- N_LOG2, 4, log2 of FFT length N; must be ≥2 (default gives a 16-point FFT).
- RD_LATENCY, 1, cycles from o_rd_en to RAM data valid at butterfly inputs.
- BF_LATENCY, 3, cycles from butterfly inputs to butterfly outputs.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_start  input  1  start request; sampled only in IDLE.
- o_busy  output  1  high in RUN, DRAIN and DONE.
- o_done  output  1  one-cycle pulse when the FFT is complete.
- o_stage  output  N_LOG2 (width $clog2(N_LOG2)+1 acceptable)  current stage index s.
- o_rd_en  output  1  read strobe for both RAM ports.
- o_rd_addr_a  output  N_LOG2  RAM port A read address (top input a).
- o_rd_addr_b  output  N_LOG2  RAM port B read address (bottom input b).
- o_tw_addr  output  N_LOG2-1  twiddle ROM index k (W_N^k); issued together with the read addresses.
- o_wr_en  output  1  write strobe for both RAM ports.
- o_wr_addr_a  output  N_LOG2  write address for butterfly output a.
- o_wr_addr_b  output  N_LOG2  write address for butterfly output b.

## Operation
- PIPE = RD_LATENCY + BF_LATENCY. Half = N/2 butterflies per stage.
- States and transitions:
  - IDLE: goes to RUN when i_start=1. Stage and butterfly counters are cleared.
  - RUN: goes to DRAIN after the cycle with j = N/2-1.
  - DRAIN: goes to RUN (with s+1) after PIPE cycles, or to DONE if s = N_LOG2-1.
  - DONE: goes to IDLE after one cycle.
- RUN: one butterfly per cycle. j counts 0..N/2-1, o_rd_en=1.
- Address generation for stage s and butterfly index j:
  - half_s = 1<<s; pos = j & (half_s-1); grp = j >> s.
  - a = (grp << (s+1)) | pos; b = a + half_s.
  - tw = pos << (N_LOG2-1-s).
  - All arithmetic is unsigned, in N_LOG2 bits, with no wrap possible.
- Write-back path:
  - {rd_en, a, b} enters a PIPE-deep shift register.
  - Its output drives o_wr_en, o_wr_addr_a and o_wr_addr_b.
  - The shift register advances every cycle regardless of state.
- Input ordering is bit-reversed; the controller does not reorder. Output is natural order.
- i_start is ignored while o_busy=1. There is no abort; rst is the only way to stop a transform.
- The reset value of every output is 0. The state is IDLE and all shift-register valid bits are cleared.
- Reset mid-operation: o_rd_en and o_wr_en drop immediately (asynchronous). No stale writes occur after reset is released.

## Timing
- i_start is sampled high at edge 0. RUN occupies cycles 1..N/2, with o_rd_en, addresses and o_busy valid from cycle 1.
- A read issued in cycle t produces o_wr_en with the same a/b in cycle t+PIPE.
- Per stage: N/2 RUN cycles plus PIPE DRAIN cycles. The last write of a stage lands in the last DRAIN cycle. The next stage's first read follows in the next cycle, so a write is never overlapped with a read of the same stage boundary.
- Total: o_done is high in cycle N_LOG2·(N/2+PIPE)+1. The default configuration gives cycle 49.
- o_busy stays high through the DONE cycle. IDLE is reached the cycle after, where a new i_start is accepted.
- i_start held high continuously: back-to-back transforms run, each starting the cycle after IDLE is re-entered.
- o_stage holds its value through DRAIN and updates on entry to the next RUN.
- o_rd_en and o_wr_en are never both high in DRAIN-only cycles except for trailing writes. Exactly N/2 writes occur per stage.

## Test plan
- Default params, single i_start pulse: checks the read pattern per stage.
  - s0 reads (0,1),(2,3)…(14,15) with tw=0.
  - s1 j=1 → (1,3), tw=4.
  - s3 j=7 → (7,15), tw=7.
  - o_done is high only in cycle 49; o_busy is high in cycles 1..49.
- Write alignment: each o_wr_en pulse is 4 cycles after its read, with identical a/b. Count exactly 8 writes per stage and 32 in total.
- Stage boundary: there is no o_rd_en in the 4 DRAIN cycles, and the s1 first read at (0,2) comes one cycle after the s0 final write (14,15).
- i_start pulses during busy at cycles 5 and 30 are ignored, so only one o_done occurs. With i_start held high, a second transform's first read occurs at cycle 51.
- rst asserted at cycle 20 (mid s1): all outputs go to 0 immediately. There are no writes after deassertion, and a fresh i_start restarts from s0 j=0.
- Parameter sweep: N_LOG2=2, BF_LATENCY=1 gives reads s0 (0,1),(2,3) and s1 (0,2),(1,3) with tw 0,1. o_done is high in cycle 2·(2+2)+1 = 9.

Source files
------------

// File: rtl/fft_stage_controller.sv
// Address sequencer for an in-place radix-2 DIT FFT: walks every stage, issues
// butterfly read/twiddle addresses and replays them as write-backs after the datapath latency.
module fft_stage_controller #(
  parameter int N_LOG2     = 4,
  parameter int RD_LATENCY = 1,
  parameter int BF_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [N_LOG2-1:0] o_stage,
  output logic              o_rd_en,
  output logic [N_LOG2-1:0] o_rd_addr_a,
  output logic [N_LOG2-1:0] o_rd_addr_b,
  output logic [N_LOG2-2:0] o_tw_addr,
  output logic              o_wr_en,
  output logic [N_LOG2-1:0] o_wr_addr_a,
  output logic [N_LOG2-1:0] o_wr_addr_b
);

  localparam int PIPE  = RD_LATENCY + BF_LATENCY;
  localparam int CNT_W = $clog2(PIPE + 1);

  localparam logic [N_LOG2-1:0] STAGE_ONE  = N_LOG2'(1);
  localparam logic [N_LOG2-1:0] STAGE_LAST = N_LOG2'(N_LOG2 - 1);
  localparam logic [N_LOG2-2:0] J_ONE      = (N_LOG2 - 1)'(1);
  localparam logic [N_LOG2-2:0] J_LAST     = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PIPE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_LOG2-1:0] stage_q, stage_d;
  logic [N_LOG2-2:0] j_q, j_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pipe_en_q [PIPE];
  logic [N_LOG2-1:0] pipe_a_q  [PIPE];
  logic [N_LOG2-1:0] pipe_b_q  [PIPE];

  // Butterfly j of stage s pairs a with a + 2^s, where a has a zero at bit s.
  function automatic logic [N_LOG2-1:0] calcA(input logic [N_LOG2-1:0] s,
                                              input logic [N_LOG2-2:0] j);
    logic [N_LOG2-1:0] jx, half, pos, grp;
    jx   = {1'b0, j};
    half = STAGE_ONE << s;
    pos  = jx & (half - STAGE_ONE);
    grp  = jx >> s;
    return (grp << (s + STAGE_ONE)) | pos;
  endfunction

  function automatic logic [N_LOG2-2:0] calcTw(input logic [N_LOG2-1:0] s,
                                               input logic [N_LOG2-2:0] j);
    logic [N_LOG2-1:0] jx, pos, tw;
    jx  = {1'b0, j};
    pos = jx & ((STAGE_ONE << s) - STAGE_ONE);
    tw  = pos << (STAGE_LAST - s);
    return tw[N_LOG2-2:0];
  endfunction

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        stage_d = '0;
        j_d     = '0;
        cnt_d   = '0;
        if (i_start) state_d = RUN;
      end
      RUN: begin
        if (j_q == J_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          j_d = j_q + J_ONE;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + STAGE_ONE;
            j_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rd_en     <= 1'b0;
      o_rd_addr_a <= '0;
      o_rd_addr_b <= '0;
      o_tw_addr   <= '0;
      for (int i = 0; i < PIPE; i++) begin
        pipe_en_q[i] <= 1'b0;
        pipe_a_q[i]  <= '0;
        pipe_b_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      o_busy  <= (state_d != IDLE);
      o_done  <= (state_d == DONE);
      o_rd_en <= (state_d == RUN);
      if (state_d == RUN) begin
        o_rd_addr_a <= calcA(stage_d, j_d);
        o_rd_addr_b <= calcA(stage_d, j_d) + (STAGE_ONE << stage_d);
        o_tw_addr   <= calcTw(stage_d, j_d);
      end else begin
        o_rd_addr_a <= '0;
        o_rd_addr_b <= '0;
        o_tw_addr   <= '0;
      end
      pipe_en_q[0] <= o_rd_en;
      pipe_a_q[0]  <= o_rd_addr_a;
      pipe_b_q[0]  <= o_rd_addr_b;
      for (int i = 1; i < PIPE; i++) begin
        pipe_en_q[i] <= pipe_en_q[i-1];
        pipe_a_q[i]  <= pipe_a_q[i-1];
        pipe_b_q[i]  <= pipe_b_q[i-1];
      end
    end
  end

  assign o_stage     = stage_q;
  assign o_wr_en     = pipe_en_q[PIPE-1];
  assign o_wr_addr_a = pipe_a_q[PIPE-1];
  assign o_wr_addr_b = pipe_b_q[PIPE-1];

endmodule

// File: tb/tb_fft_stage_controller.sv
// Directed bench for fft_stage_controller: default 16-point instance plus a 4-point,
// short-pipeline instance sharing clock and reset.
module tb_fft_stage_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start2;

  logic       busy, done, rdEn, wrEn;
  logic [3:0] stage, rdA, rdB, wrA, wrB;
  logic [2:0] tw;

  logic       busy2, done2, rdEn2, wrEn2;
  logic [1:0] stage2, rdA2, rdB2, wrA2, wrB2;
  logic [0:0] tw2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_stage_controller dut (
    .clk(clk), .rst(rst), .i_start(start),
    .o_busy(busy), .o_done(done), .o_stage(stage),
    .o_rd_en(rdEn), .o_rd_addr_a(rdA), .o_rd_addr_b(rdB), .o_tw_addr(tw),
    .o_wr_en(wrEn), .o_wr_addr_a(wrA), .o_wr_addr_b(wrB)
  );

  fft_stage_controller #(.N_LOG2(2), .RD_LATENCY(1), .BF_LATENCY(1)) dutSmall (
    .clk(clk), .rst(rst), .i_start(start2),
    .o_busy(busy2), .o_done(done2), .o_stage(stage2),
    .o_rd_en(rdEn2), .o_rd_addr_a(rdA2), .o_rd_addr_b(rdB2), .o_tw_addr(tw2),
    .o_wr_en(wrEn2), .o_wr_addr_a(wrA2), .o_wr_addr_b(wrB2)
  );

  // Reference schedule for the 16-point run: 12 cycles per stage, reads in the first 8.
  function automatic void refRead(input int c, output logic en, output logic [3:0] a,
                                  output logic [3:0] b, output logic [2:0] t, output logic [3:0] s);
    int off, j, span, lo;
    en = 1'b0; a = '0; b = '0; t = '0; s = '0;
    if (c >= 1 && c <= 48) begin
      s   = 4'((c - 1) / 12);
      off = (c - 1) % 12;
      if (off < 8) begin
        j    = off;
        span = 1 << s;
        lo   = j % span;
        en   = 1'b1;
        a    = 4'((j / span) * (2 * span) + lo);
        b    = 4'((j / span) * (2 * span) + lo + span);
        t    = 3'(lo * (8 / span));
      end
    end
  endfunction

  task automatic startPulse();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    while (busy === 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL waitIdle busy=%0b after %0d cycles, expected 0", busy, bound);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, stage, rdEn, rdA, rdB, tw, wrEn, wrA, wrB} !== 26'b0) begin
      errors++;
      $display("[TB] FAIL reset outputs got %h expected 0",
               {busy, done, stage, rdEn, rdA, rdB, tw, wrEn, wrA, wrB});
    end
    checks++;
    if ({busy2, done2, stage2, rdEn2, rdA2, rdB2, tw2, wrEn2, wrA2, wrB2} !== 16'b0) begin
      errors++;
      $display("[TB] FAIL reset small outputs got %h expected 0",
               {busy2, done2, stage2, rdEn2, rdA2, rdB2, tw2, wrEn2, wrA2, wrB2});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_run();
    int wrCount [4] = '{0, 0, 0, 0};
    int total = 0;
    logic eRd, eWr, dummy;
    logic [3:0] eA, eB, eS, wA, wB, ds;
    logic [2:0] eT, dt;
    startPulse();
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      refRead(c, eRd, eA, eB, eT, eS);
      refRead(c - 4, eWr, wA, wB, dt, ds);
      checks++;
      if (rdEn !== eRd || busy !== (c <= 49) || done !== (c == 49) || wrEn !== eWr) begin
        errors++;
        $display("[TB] FAIL ctrl c=%0d got rd=%0b busy=%0b done=%0b wr=%0b expected %0b %0b %0b %0b",
                 c, rdEn, busy, done, wrEn, eRd, c <= 49, c == 49, eWr);
      end
      if (eRd) begin
        checks++;
        if (rdA !== eA || rdB !== eB || tw !== eT || stage !== eS) begin
          errors++;
          $display("[TB] FAIL read c=%0d got (%0d,%0d) tw=%0d s=%0d expected (%0d,%0d) tw=%0d s=%0d",
                   c, rdA, rdB, tw, stage, eA, eB, eT, eS);
        end
      end
      if (eWr) begin
        checks++;
        if (wrA !== wA || wrB !== wB) begin
          errors++;
          $display("[TB] FAIL write c=%0d got (%0d,%0d) expected (%0d,%0d)", c, wrA, wrB, wA, wB);
        end
      end
      if (c == 12) begin
        checks++;
        if (wrEn !== 1'b1 || wrA !== 4'd14 || wrB !== 4'd15) begin
          errors++;
          $display("[TB] FAIL s0_last_write got wr=%0b (%0d,%0d) expected 1 (14,15)", wrEn, wrA, wrB);
        end
      end
      if (c == 13) begin
        checks++;
        if (rdEn !== 1'b1 || rdA !== 4'd0 || rdB !== 4'd2 || stage !== 4'd1) begin
          errors++;
          $display("[TB] FAIL s1_first_read got rd=%0b (%0d,%0d) s=%0d expected 1 (0,2) s=1",
                   rdEn, rdA, rdB, stage);
        end
      end
      if (wrEn === 1'b1) begin
        total++;
        if (c <= 48) wrCount[(c - 1) / 12]++;
      end
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (wrCount[s] != 8) begin
        errors++;
        $display("[TB] FAIL writes_per_stage s=%0d got %0d expected 8", s, wrCount[s]);
      end
    end
    checks++;
    if (total != 32) begin
      errors++;
      $display("[TB] FAIL writes_total got %0d expected 32", total);
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int doneCycle = -1;
    startPulse();
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        doneCycle = c;
      end
      if (c == 5 || c == 30) start = 1'b1;
      if (c == 6 || c == 31) start = 1'b0;
    end
    checks++;
    if (dones != 1 || doneCycle != 49) begin
      errors++;
      $display("[TB] FAIL start_ignored got %0d dones (last c=%0d) expected 1 at 49", dones, doneCycle);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_ignored_idle busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk);
      if (c == 49) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_done got done=%0b busy=%0b expected 1 1", done, busy);
        end
      end
      if (c == 50) begin
        checks++;
        if (busy !== 1'b0 || rdEn !== 1'b0) begin
          errors++;
          $display("[TB] FAIL b2b_idle got busy=%0b rd=%0b expected 0 0", busy, rdEn);
        end
      end
      if (c == 51) begin
        checks++;
        if (rdEn !== 1'b1 || rdA !== 4'd0 || rdB !== 4'd1 || stage !== 4'd0 || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_restart got rd=%0b (%0d,%0d) s=%0d busy=%0b expected 1 (0,1) 0 1",
                   rdEn, rdA, rdB, stage, busy);
        end
      end
    end
    start = 1'b0;
    waitIdle(120);
  endtask

  task automatic test_mid_reset();
    int strayWr = 0;
    int strayRd = 0;
    startPulse();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, stage, rdEn, rdA, rdB, tw, wrEn, wrA, wrB} !== 26'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset outputs got %h expected 0",
               {busy, done, stage, rdEn, rdA, rdB, tw, wrEn, wrA, wrB});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wrEn !== 1'b0) strayWr++;
      if (rdEn !== 1'b0) strayRd++;
    end
    checks++;
    if (strayWr != 0 || strayRd != 0) begin
      errors++;
      $display("[TB] FAIL post_reset_quiet got %0d writes %0d reads expected 0 0", strayWr, strayRd);
    end
    startPulse();
    @(negedge clk);
    checks++;
    if (rdEn !== 1'b1 || rdA !== 4'd0 || rdB !== 4'd1 || tw !== 3'd0 || stage !== 4'd0) begin
      errors++;
      $display("[TB] FAIL restart got rd=%0b (%0d,%0d) tw=%0d s=%0d expected 1 (0,1) 0 0",
               rdEn, rdA, rdB, tw, stage);
    end
    waitIdle(80);
  endtask

  // 4-point, PIPE=2: stage 0 reads in cycles 1-2, stage 1 in cycles 5-6.
  function automatic void refSmall(input int c, output logic en, output logic [1:0] a,
                                   output logic [1:0] b, output logic [0:0] t);
    en = 1'b1; a = 2'd0; b = 2'd0; t = 1'b0;
    case (c)
      1:       begin a = 2'd0; b = 2'd1; end
      2:       begin a = 2'd2; b = 2'd3; end
      5:       begin a = 2'd0; b = 2'd2; end
      6:       begin a = 2'd1; b = 2'd3; t = 1'b1; end
      default: en = 1'b0;
    endcase
  endfunction

  task automatic test_param_small();
    logic eRd, eWr;
    logic [1:0] eA, eB, wA, wB;
    logic [0:0] eT, dt;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      refSmall(c, eRd, eA, eB, eT);
      refSmall(c - 2, eWr, wA, wB, dt);
      checks++;
      if (rdEn2 !== eRd || wrEn2 !== eWr || done2 !== (c == 9) || busy2 !== (c <= 9)) begin
        errors++;
        $display("[TB] FAIL small_ctrl c=%0d got rd=%0b wr=%0b done=%0b busy=%0b expected %0b %0b %0b %0b",
                 c, rdEn2, wrEn2, done2, busy2, eRd, eWr, c == 9, c <= 9);
      end
      if (eRd) begin
        checks++;
        if (rdA2 !== eA || rdB2 !== eB || tw2 !== eT) begin
          errors++;
          $display("[TB] FAIL small_read c=%0d got (%0d,%0d) tw=%0d expected (%0d,%0d) tw=%0d",
                   c, rdA2, rdB2, tw2, eA, eB, eT);
        end
      end
      if (eWr) begin
        checks++;
        if (wrA2 !== wA || wrB2 !== wB) begin
          errors++;
          $display("[TB] FAIL small_write c=%0d got (%0d,%0d) expected (%0d,%0d)", c, wrA2, wrB2, wA, wB);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    test_param_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
